// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, next-PC selection and the req/ack handshake
// to instruction memory for the F stage of the pipelined MIPS core.
// D-stage control transfers are remembered across an outstanding
// delay-slot fetch; exception entry and eret redirect immediately.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_valid,
    input  logic [1:0]  D_kind,
    input  logic        D_cond,
    input  logic [31:0] D_PC,
    input  logic [31:0] offset,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] F_PC,
    output logic        F_valid,
    output logic [31:0] PC8
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic        pend;
    logic [31:0] pend_pc;

    logic        advance;
    logic        D_fire;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Handshake outputs: a request is only ever raised while waiting in REQ,
    // and the fetched word is suppressed while a redirect pulse is retargeting F.
    always_comb begin
        imem_req  = (state == REQ) && !reset;
        imem_addr = F_PC;
        F_valid   = (((state == REQ) && imem_ack) || (state == HOLD))
                    && !exc_req && !eret_req && !reset;
        PC8       = D_PC + 32'd8;
    end

    // Redirect target from the D-stage instruction and the resulting next PC.
    always_comb begin
        advance  = F_valid && !stall;
        D_fire   = D_valid && !stall;
        redirect = 1'b0;
        target   = 32'h0;
        case (D_kind)
            2'd1: begin
                redirect = D_fire && D_cond;
                target   = D_PC + 32'd4 + {offset[29:0], 2'b00};
            end
            2'd2: begin
                redirect = D_fire;
                target   = {D_PC[31:28], imm26, 2'b00};
            end
            2'd3: begin
                redirect = D_fire;
                target   = ra;
            end
            default: begin
                redirect = 1'b0;
                target   = 32'h0;
            end
        endcase
        if (redirect) begin
            next_pc = target;
        end else if (pend) begin
            next_pc = pend_pc;
        end else begin
            next_pc = F_PC + 32'd4;
        end
    end

    // PC, fetch state and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC    <= RESET_PC;
            state   <= REQ;
            pend    <= 1'b0;
            pend_pc <= 32'h0;
        end else if (exc_req) begin
            F_PC  <= EXC_PC;
            state <= REQ;
            pend  <= 1'b0;
        end else if (eret_req) begin
            F_PC  <= epc;
            state <= REQ;
            pend  <= 1'b0;
        end else begin
            if (advance) begin
                F_PC  <= next_pc;
                state <= REQ;
                pend  <= 1'b0;
            end else if ((state == REQ) && imem_ack && stall) begin
                state <= HOLD;
            end
            if (redirect && !advance) begin
                pend    <= 1'b1;
                pend_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenario tests for pc_fetch_ctrl with
// hand-computed expected fetch addresses and handshake outputs.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        D_valid;
    logic [1:0]  D_kind;
    logic        D_cond;
    logic [31:0] D_PC;
    logic [31:0] offset;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] F_PC;
    logic        F_valid;
    logic [31:0] PC8;

    int vectors = 0;
    int miscompares = 0;

    pc_fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .D_valid   (D_valid),
        .D_kind    (D_kind),
        .D_cond    (D_cond),
        .D_PC      (D_PC),
        .offset    (offset),
        .imm26     (imm26),
        .ra        (ra),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .F_PC      (F_PC),
        .F_valid   (F_valid),
        .PC8       (PC8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall    = 1'b0;
        D_valid  = 1'b0;
        D_kind   = 2'd0;
        D_cond   = 1'b0;
        D_PC     = 32'h0;
        offset   = 32'h0;
        imm26    = 26'h0;
        ra       = 32'h0;
        exc_req  = 1'b0;
        eret_req = 1'b0;
        epc      = 32'h0;
        imem_ack = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic advance_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
        end
        vectors++;
        if (F_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_fvalid: got %b expected 0", F_valid);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_addr !== 32'h3000 || F_valid !== 1'b1 || imem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL seq0: addr %h valid %b req %b expected 3000 1 1", imem_addr, F_valid, imem_req);
        end
        step();
        vectors++;
        if (imem_addr !== 32'h3004 || F_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL seq1: addr %h valid %b expected 3004 1", imem_addr, F_valid);
        end
        step();
        vectors++;
        if (imem_addr !== 32'h3008 || F_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL seq2: addr %h valid %b expected 3008 1", imem_addr, F_valid);
        end
    endtask

    task automatic test_branch_same_cycle();
        do_reset();
        advance_n(3);
        D_valid = 1'b1; D_kind = 2'd1; D_cond = 1'b1; D_PC = 32'h3008; offset = 32'd3;
        #1;
        vectors++;
        if (PC8 !== 32'h3010) begin
            miscompares++;
            $display("[TB] FAIL pc8: got %h expected 3010", PC8);
        end
        step();
        D_valid = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3018) begin
            miscompares++;
            $display("[TB] FAIL br_target: got %h expected 3018", F_PC);
        end
        step();
        vectors++;
        if (F_PC !== 32'h301C) begin
            miscompares++;
            $display("[TB] FAIL br_after: got %h expected 301c", F_PC);
        end
    endtask

    task automatic test_branch_pending();
        do_reset();
        advance_n(3);
        imem_ack = 1'b0;
        D_valid = 1'b1; D_kind = 2'd1; D_cond = 1'b1; D_PC = 32'h3008; offset = 32'd3;
        step();
        D_valid = 1'b0;
        #1;
        vectors++;
        if (dut.pend !== 1'b1 || F_PC !== 32'h300C || F_valid !== 1'b0 || imem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pend_set: pend %b pc %h valid %b req %b expected 1 300c 0 1", dut.pend, F_PC, F_valid, imem_req);
        end
        step();
        imem_ack = 1'b1;
        #1;
        vectors++;
        if (F_PC !== 32'h300C || F_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL slot_deliver: pc %h valid %b expected 300c 1", F_PC, F_valid);
        end
        step();
        vectors++;
        if (F_PC !== 32'h3018 || dut.pend !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pend_use: pc %h pend %b expected 3018 0", F_PC, dut.pend);
        end
        step();
        vectors++;
        if (F_PC !== 32'h301C) begin
            miscompares++;
            $display("[TB] FAIL pend_once: got %h expected 301c", F_PC);
        end
    endtask

    task automatic test_hold();
        do_reset();
        advance_n(4);
        stall = 1'b1;
        #1;
        vectors++;
        if (F_PC !== 32'h3010 || F_valid !== 1'b1 || imem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_enter: pc %h valid %b req %b expected 3010 1 1", F_PC, F_valid, imem_req);
        end
        step();
        imem_ack = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3010 || F_valid !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_stay: pc %h valid %b req %b expected 3010 1 0", F_PC, F_valid, imem_req);
        end
        stall = 1'b0;
        step();
        vectors++;
        if (F_PC !== 32'h3014 || imem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_release: pc %h req %b expected 3014 1", F_PC, imem_req);
        end
    endtask

    task automatic test_exc_eret();
        do_reset();
        advance_n(3);
        imem_ack = 1'b0;
        D_valid = 1'b1; D_kind = 2'd1; D_cond = 1'b1; D_PC = 32'h3008; offset = 32'd3;
        step();
        D_valid = 1'b0;
        exc_req = 1'b1;
        imem_ack = 1'b1;
        #1;
        vectors++;
        if (dut.pend !== 1'b1 || F_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL exc_pulse: pend %b valid %b expected 1 0", dut.pend, F_valid);
        end
        step();
        exc_req = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h4180 || dut.pend !== 1'b0 || F_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL exc_entry: pc %h pend %b valid %b expected 4180 0 1", F_PC, dut.pend, F_valid);
        end
        step();
        vectors++;
        if (F_PC !== 32'h4184) begin
            miscompares++;
            $display("[TB] FAIL exc_seq: got %h expected 4184", F_PC);
        end
        eret_req = 1'b1;
        epc = 32'h3040;
        #1;
        vectors++;
        if (F_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL eret_pulse: valid %b expected 0", F_valid);
        end
        step();
        eret_req = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3040) begin
            miscompares++;
            $display("[TB] FAIL eret_target: got %h expected 3040", F_PC);
        end
        exc_req = 1'b1;
        eret_req = 1'b1;
        step();
        exc_req = 1'b0;
        eret_req = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h4180) begin
            miscompares++;
            $display("[TB] FAIL exc_priority: got %h expected 4180", F_PC);
        end
    endtask

    task automatic test_jumps_reset();
        do_reset();
        advance_n(1);
        D_valid = 1'b1; D_kind = 2'd3; D_PC = 32'h3000; ra = 32'h3100;
        step();
        D_valid = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3100) begin
            miscompares++;
            $display("[TB] FAIL jr_target: got %h expected 3100", F_PC);
        end
        step();
        vectors++;
        if (F_PC !== 32'h3104) begin
            miscompares++;
            $display("[TB] FAIL jr_slot: got %h expected 3104", F_PC);
        end
        D_valid = 1'b1; D_kind = 2'd2; D_PC = 32'h3100; imm26 = 26'h0000C40;
        step();
        D_valid = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3100) begin
            miscompares++;
            $display("[TB] FAIL j_target: got %h expected 3100", F_PC);
        end
        stall = 1'b1;
        step();
        vectors++;
        if (imem_req !== 1'b0 || F_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL j_hold: req %b valid %b expected 0 1", imem_req, F_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || F_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_hold: req %b valid %b expected 0 0", imem_req, F_valid);
        end
        step();
        reset = 1'b0;
        imem_ack = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3000 || imem_req !== 1'b1 || dut.pend !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_exit: pc %h req %b pend %b expected 3000 1 0", F_PC, imem_req, dut.pend);
        end
        stall = 1'b0;
    endtask

    task automatic test_not_taken_and_backward();
        do_reset();
        advance_n(1);
        D_valid = 1'b1; D_kind = 2'd1; D_cond = 1'b0; D_PC = 32'h3000; offset = 32'd5;
        step();
        vectors++;
        if (F_PC !== 32'h3008) begin
            miscompares++;
            $display("[TB] FAIL not_taken: got %h expected 3008", F_PC);
        end
        D_cond = 1'b1; D_PC = 32'h3004; offset = 32'hFFFF_FFFE;
        step();
        D_valid = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL back_branch: got %h expected 3000", F_PC);
        end
        D_valid = 1'b1; D_kind = 2'd2; D_PC = 32'h3000; imm26 = 26'h0000400;
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        D_valid = 1'b0;
        #1;
        vectors++;
        if (F_PC !== 32'h3000 || dut.pend !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_no_fire: pc %h pend %b expected 3000 0", F_PC, dut.pend);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_branch_same_cycle();
        test_branch_pending();
        test_hold();
        test_exc_eret();
        test_jumps_reset();
        test_not_taken_and_backward();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Next-generation PC unit for the pipelined MIPS core. It merges the PC register and next-PC selection with a req/ack instruction-memory handshake, so the F stage tolerates multi-cycle fetch latency. D-stage control transfers (branch, j/jal, jr) are honoured across the delay slot even when the delay-slot fetch is still outstanding. Exception entry and eret redirection are built in. Sits between the hazard unit, the D stage and instruction memory.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_PC, 32'h0000_4180, exception entry address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall  in  1  freeze F/D, from the hazard unit
D_valid  in  1  D holds a real instruction
D_kind  in  2  0 none, 1 conditional branch, 2 j/jal, 3 jr/jalr
D_cond  in  1  branch condition true (valid when D_kind=1)
D_PC  in  32  PC of the D-stage instruction
offset  in  32  sign-extended imm16
imm26  in  26  jump index
ra  in  32  forwarded rs value for jr
exc_req  in  1  one-cycle exception pulse from a later stage
eret_req  in  1  one-cycle eret pulse
epc  in  32  eret return address
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; always equals F_PC
imem_ack  in  1  instruction for imem_addr returned this cycle
F_PC  out  32  current fetch PC
F_valid  out  1  F instruction valid this cycle
PC8  out  32  D_PC+8, the link value

Behaviour:
- Two states:
  - REQ: imem_req=1; waiting for ack.
  - HOLD: instruction returned but F stalled; imem_req=0.
- Reset (synchronous):
  - F_PC=RESET_PC; state=REQ; pend=0; pend_pc=0.
  - imem_req=0 and F_valid=0 during any cycle with reset=1.
  - Reset overrides all other inputs in any state, including mid-wait.
- Fetch outputs:
  - F_valid = (REQ & imem_ack) | HOLD, gated off in exc/eret cycles.
  - F_PC is held stable while in REQ without ack.
- Advance = F_valid & !stall. On advance, F_PC <= next, state <= REQ.
- In REQ, imem_ack & stall moves to HOLD. HOLD stays until !stall, which is an advance.
- D_fire = D_valid & !stall. Redirect target computed when D_fire:
  - Kind 1, cond=1: D_PC+4+(offset<<2), 32-bit wraparound.
  - Kind 1, cond=0: no redirect; sequential fetch equals D_PC+8.
  - Kind 2: {D_PC[31:28], imm26, 2'b00}.
  - Kind 3: ra, used unmodified with no alignment check.
- next PC:
  - If a same-cycle redirect from D_fire exists, use its target.
  - Else if pend, use pend_pc.
  - Else use F_PC+4.
- Pending redirect:
  - On D_fire with a redirect and no same-cycle advance: pend<=1, pend_pc<=target.
  - pend clears on the next advance.
  - Consumed exactly once, after the delay slot is delivered.
- Exception and eret:
  - exc_req: F_PC<=EXC_PC, state<=REQ, pend<=0. This ignores stall, any outstanding ack, and any D redirect.
  - eret_req: same, with F_PC<=epc.
  - exc_req wins over eret_req.
  - Memory contract: imem_ack always refers to the address currently on imem_addr, so an address change abandons the old request.
- PC8 = D_PC+8, combinational.

Test Plan:
- Reset, ack tied high -> imem_req=0 during reset; after release, imem_addr sequence is 0x3000, 0x3004, 0x3008; F_valid=1 each cycle.
- Taken branch D_PC=0x3008, offset=3, delay slot 0x300C acked in the same cycle -> next imem_addr=0x3018; then 0x301C.
- Same branch with 3-cycle ack latency on 0x300C -> pend=1 after D_fire; 0x300C delivered; next addr=0x3018; pend=0 afterwards.
- Ack at 0x3010 with stall held 2 cycles -> HOLD, F_valid=1, imem_req=0, F_PC=0x3010 throughout; advances to 0x3014 when stall drops.
- exc_req while pend=1 and fetch outstanding -> next cycle F_PC=0x4180, pend=0, F_valid=0 in the pulse cycle. Later eret_req with epc=0x3040 -> F_PC=0x3040. Both pulses together -> 0x4180.
- jr with ra=0x3100 in D, then j imm26=0x0000C40 with D_PC=0x3100, then reset asserted during HOLD -> 0x3100 after the delay slot, then 0x3100 again; reset returns F_PC to 0x3000, state REQ, pend=0.
